round_scorer: RTL

Match-level scoreboard for the tug-of-war game, sitting directly downstream of the playfield light chain. It watches the two end lights and the conditioned player presses, detects round wins, and keeps a per-player round count on two seven-segment digits. After each win it pulses a round-restart to the playfield and holds the board in a final state once a player reaches the match score. At top level, the playfield lights reset on `Reset | roundReset`.

---
 rtl/round_scorer.sv | 119 +++++++++++
 1 files changed

// File: rtl/round_scorer.sv
// Tug-of-war match scoreboard: detects round wins from the end lights,
// counts rounds per player and holds the board once the match is decided.
module round_scorer #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       L,
  input  logic       R,
  input  logic       MostLeft,
  input  logic       MostRight,
  output logic       roundReset,
  output logic [2:0] leftScore,
  output logic [2:0] rightScore,
  output logic [6:0] HEX_L,
  output logic [6:0] HEX_R,
  output logic       matchOver,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [2:0] WIN_LAST  = 3'(WIN_SCORE);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [2:0] left_q;
  logic [2:0] right_q;
  logic [1:0] winner_q;

  logic       left_win;
  logic       right_win;
  logic [2:0] left_nxt;
  logic [2:0] right_nxt;

  // A simultaneous press never scores, matching the playfield.
  assign left_win  = MostLeft & L & ~R;
  assign right_win = MostRight & R & ~L;
  assign left_nxt  = left_q + 3'd1;
  assign right_nxt = right_q + 3'd1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= PLAY;
      hold_cnt <= '0;
      left_q   <= '0;
      right_q  <= '0;
      winner_q <= 2'b00;
    end else begin
      unique case (state)
        PLAY: begin
          if (left_win) begin
            left_q <= left_nxt;
            if (left_nxt == WIN_LAST) begin
              state    <= OVER;
              winner_q <= 2'b10;
            end else begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end else if (right_win) begin
            right_q <= right_nxt;
            if (right_nxt == WIN_LAST) begin
              state    <= OVER;
              winner_q <= 2'b01;
            end else begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (hold_cnt == HOLD_LAST) begin
            state <= PLAY;
          end
        end
        OVER: begin
          state <= OVER;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [2:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (v)
      3'd0: s = 7'b1000000;
      3'd1: s = 7'b1111001;
      3'd2: s = 7'b0100100;
      3'd3: s = 7'b0110000;
      3'd4: s = 7'b0011001;
      3'd5: s = 7'b0010010;
      3'd6: s = 7'b0000010;
      3'd7: s = 7'b1111000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign roundReset = (state != PLAY);
  assign matchOver  = (state == OVER);
  assign winner     = winner_q;
  assign leftScore  = left_q;
  assign rightScore = right_q;
  assign HEX_L      = seg7(left_q);
  assign HEX_R      = seg7(right_q);

endmodule
